angle_dispatch_scheduler: RTL
=============================

Name: angle_dispatch_scheduler

Overview:
Dispatches FBP angle projections (FFT_N 64-bit beats each) to the first free back-projection pipeline in round-robin order, with real backpressure. It replaces blind cyclic switching. It sits between the filtered-projection stream and the PIPELINES_NUM back-projection pipelines. It tracks per-pipeline busy state from completion pulses and reports frame completion.

Parameters:
FFT_N, 512, beats per angle projection
PIPELINES_NUM, 60, number of back-projection pipelines
ANGLES_NUM, 360, angle projections per frame
(derived) FFT_N_W = clog2(FFT_N), PIPE_W = clog2(PIPELINES_NUM), ANG_W = clog2(ANGLES_NUM)

Ports:
clk  in  1  clock
arstn  in  1  reset, synchronous, active-low
frame_start  in  1  one-cycle pulse; arms a new frame
s_data  in  64  input projection beat
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid & s_ready
m_data  out  64  broadcast beat to all pipelines (0 when no beat)
m_valid  out  PIPELINES_NUM  one-hot per-pipeline beat strobe
pipe_done  in  PIPELINES_NUM  per-pipeline one-cycle completion pulse
pipe_busy  out  PIPELINES_NUM  busy flags
cur_pipe  out  PIPE_W  pipeline currently receiving
angle_idx  out  ANG_W  index of angle being streamed
frame_done  out  1  one-cycle pulse, frame complete

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; rr_ptr=0; beat_cnt=0; angle_cnt=0.
- FSM states: IDLE, SELECT, STREAM, WAIT_DONE.
- IDLE: s_ready=0. On frame_start go to SELECT and clear angle_cnt.
- SELECT: s_ready=0. Search for a free pipeline (~pipe_busy) starting at rr_ptr and wrapping modulo PIPELINES_NUM.
  - If found: latch cur_pipe, go to STREAM next cycle.
  - If none free: stay in SELECT and re-evaluate every cycle.
  - Min cost: 1 bubble cycle per angle.
- STREAM: s_ready=1.
  - Each accepted beat: m_data<=s_data and m_valid[cur_pipe]<=1, registered, 1-cycle latency.
  - Otherwise m_valid=0 and m_data=0.
  - beat_cnt wraps at FFT_N-1.
  - On last beat: set pipe_busy[cur_pipe]; rr_ptr<=cur_pipe+1 (wraps to 0 at PIPELINES_NUM-1).
  - After last beat: if angle_cnt==ANGLES_NUM-1 go to WAIT_DONE; else increment angle_cnt and go to SELECT.
- WAIT_DONE: s_ready=0. When pipe_busy==0, pulse frame_done for 1 cycle, go to IDLE.
- pipe_done[i] clears pipe_busy[i] on the next edge.
  - pipe_done on a non-busy pipeline is ignored.
  - Set of pipe X and clear of pipe Y in the same cycle both apply.
  - Set and clear on the same index cannot occur: a streaming pipeline is not busy, so the set wins.
- A pipe_done arriving during SELECT makes that pipeline eligible the following cycle.
- frame_start outside IDLE is ignored.
- s_valid low mid-angle: hold state and beat_cnt; no m_valid.
- Reset asserted mid-operation: everything returns to reset values next edge. Partial angle is dropped; busy flags cleared.
- angle_idx = angle_cnt; cur_pipe is held stable through STREAM.

Optional Feature:
Macro DISPATCH_STALL_STATS_EN.
- With it: adds output stall_cycles [31:0], counting cycles spent in SELECT with no free pipeline.
  - Cleared on frame_start; saturates at 0xFFFFFFFF.
  - Also adds output spurious_done (sticky 1 bit), set when pipe_done hits a non-busy pipeline; cleared on frame_start.
- Without it: neither port nor logic exists; behaviour is otherwise identical.

Decomposition:
- Package fbp_dispatch_pkg: FSM state enum (IDLE, SELECT, STREAM, WAIT_DONE), clog2 function, 64-bit beat typedef.
- Sub-module rr_free_picker: combinational rotating priority encoder.
  - Inputs: free mask, rr_ptr.
  - Outputs: found, index.
  - Reusable for other pipeline-resource arbiters.

Test Plan:
1. Idle routing: FFT_N=8, PIPELINES_NUM=4, ANGLES_NUM=4, all free, continuous valid, pipe_done 2 cycles after each angle. Expect angles to go to pipes 0,1,2,3 in order; each m_valid one-hot for exactly 8 beats; one bubble between angles; frame_done once after the last done.
2. Backpressure: as above but pipe_done withheld, ANGLES_NUM=6. Expect s_ready=0 after 4 angles. Pulse pipe_done[2]: angle 4 goes to pipe 2 next SELECT; stall_cycles equals the wait length (with DISPATCH_STALL_STATS_EN).
3. Round-robin wrap: pipes 0 and 3 free, rr_ptr=3. Expect pipe 3 selected, then pipe 0 (wrap).
4. Valid gaps: toggle s_valid every other cycle mid-angle. Expect exactly FFT_N m_valid beats; data matches input order with 1-cycle latency.
5. Reset mid-stream: arstn low at beat 5 of angle 2. Expect all outputs 0 next cycle; after a new frame_start, dispatch restarts at pipe 0 with angle_idx 0.
6. Spurious done: pulse pipe_done[1] while pipe 1 is free. Expect no state change; spurious_done=1 (with macro).

Source files
------------

// File: rtl/fbp_dispatch_pkg.sv
// Shared types and helpers for the FBP angle dispatch scheduler.
//   state_e : scheduler FSM states
//   beat_t  : one 64-bit projection beat
//   clog2   : width helper, never returns less than 1
package fbp_dispatch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StStream,
        StWaitDone
    } state_e;

    typedef logic [63:0] beat_t;

    // Bits needed to index 'value' items; 1 and 2 both give 1 so vectors stay legal.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_free_picker.sv
// Rotating priority encoder: finds the first set bit of free_mask_i at or after
// rr_ptr_i, wrapping modulo N. Purely combinational.
//   free_mask_i : one bit per resource, 1 = available
//   rr_ptr_i    : index where the search starts (must be < N)
//   found_o     : at least one resource is available
//   index_o     : chosen resource (0 when found_o is low)
module rr_free_picker
    import fbp_dispatch_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = clog2(N)
) (
    input  logic [N-1:0] free_mask_i,
    input  logic [W-1:0] rr_ptr_i,
    output logic         found_o,
    output logic [W-1:0] index_o
);

    always_comb begin
        int unsigned j;
        j       = 0;
        found_o = 1'b0;
        index_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(rr_ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found_o && free_mask_i[j]) begin
                found_o = 1'b1;
                index_o = W'(j);
            end
        end
    end

endmodule

// File: rtl/angle_dispatch_scheduler.sv
// Dispatches FFT_N-beat angle projections to the first free back-projection
// pipeline in round-robin order, with backpressure towards the projection stream.
//   clk, arstn   : clock, synchronous active-low reset
//   frame_start  : pulse, arms a new frame (only honoured when idle)
//   s_data/s_valid/s_ready : input projection beat handshake
//   m_data/m_valid : registered broadcast beat and one-hot pipeline strobe
//   pipe_done/pipe_busy : per-pipeline completion pulses and busy flags
//   cur_pipe, angle_idx : pipeline being fed, angle being streamed
//   frame_done   : pulse once every angle is dispatched and all pipelines idle
// Optional (DISPATCH_STALL_STATS_EN): stall_cycles counts SELECT cycles with no
// free pipeline; spurious_done is sticky on a pipe_done to an idle pipeline.
module angle_dispatch_scheduler
    import fbp_dispatch_pkg::*;
#(
    parameter int unsigned FFT_N         = 512,
    parameter int unsigned PIPELINES_NUM = 60,
    parameter int unsigned ANGLES_NUM    = 360,
    localparam int unsigned FFT_N_W      = clog2(FFT_N),
    localparam int unsigned PIPE_W       = clog2(PIPELINES_NUM),
    localparam int unsigned ANG_W        = clog2(ANGLES_NUM)
) (
    input  logic                     clk,
    input  logic                     arstn,
    input  logic                     frame_start,
    input  beat_t                    s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output beat_t                    m_data,
    output logic [PIPELINES_NUM-1:0] m_valid,
    input  logic [PIPELINES_NUM-1:0] pipe_done,
    output logic [PIPELINES_NUM-1:0] pipe_busy,
    output logic [PIPE_W-1:0]        cur_pipe,
    output logic [ANG_W-1:0]         angle_idx,
    output logic                     frame_done
`ifdef DISPATCH_STALL_STATS_EN
    ,
    output logic [31:0]              stall_cycles,
    output logic                     spurious_done
`endif
);

    localparam logic [FFT_N_W-1:0] BeatLast = FFT_N_W'(FFT_N - 1);
    localparam logic [PIPE_W-1:0]  PipeLast = PIPE_W'(PIPELINES_NUM - 1);
    localparam logic [ANG_W-1:0]   AngLast  = ANG_W'(ANGLES_NUM - 1);

    state_e                   state_q, state_d;
    logic [PIPE_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PIPE_W-1:0]        cur_pipe_q, cur_pipe_d;
    logic [FFT_N_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [ANG_W-1:0]         angle_cnt_q, angle_cnt_d;
    logic [PIPELINES_NUM-1:0] pipe_busy_q, pipe_busy_d;
    logic [PIPELINES_NUM-1:0] m_valid_q, m_valid_d;
    beat_t                    m_data_q, m_data_d;
    logic                     frame_done_q, frame_done_d;
    logic [PIPELINES_NUM-1:0] set_mask;
    logic                     pick_found;
    logic [PIPE_W-1:0]        pick_idx;

    rr_free_picker #(
        .N (PIPELINES_NUM),
        .W (PIPE_W)
    ) u_picker (
        .free_mask_i (~pipe_busy_q),
        .rr_ptr_i    (rr_ptr_q),
        .found_o     (pick_found),
        .index_o     (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cur_pipe_d   = cur_pipe_q;
        beat_cnt_d   = beat_cnt_q;
        angle_cnt_d  = angle_cnt_q;
        m_valid_d    = '0;
        m_data_d     = '0;
        frame_done_d = 1'b0;
        set_mask     = '0;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    angle_cnt_d = '0;
                    state_d     = StSelect;
                end
            end
            StSelect: begin
                // No free pipeline: stay here and retry with next cycle's busy flags.
                if (pick_found) begin
                    cur_pipe_d = pick_idx;
                    state_d    = StStream;
                end
            end
            StStream: begin
                if (s_valid) begin
                    m_valid_d[cur_pipe_q] = 1'b1;
                    m_data_d              = s_data;
                    if (beat_cnt_q == BeatLast) begin
                        beat_cnt_d           = '0;
                        set_mask[cur_pipe_q] = 1'b1;
                        rr_ptr_d = (cur_pipe_q == PipeLast) ? '0 : cur_pipe_q + PIPE_W'(1);
                        if (angle_cnt_q == AngLast) begin
                            state_d = StWaitDone;
                        end else begin
                            angle_cnt_d = angle_cnt_q + ANG_W'(1);
                            state_d     = StSelect;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + FFT_N_W'(1);
                    end
                end
            end
            StWaitDone: begin
                if (pipe_busy_q == '0) begin
                    frame_done_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // The streaming pipeline is never busy, so set and clear never collide.
        pipe_busy_d = (pipe_busy_q & ~pipe_done) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            cur_pipe_q   <= '0;
            beat_cnt_q   <= '0;
            angle_cnt_q  <= '0;
            pipe_busy_q  <= '0;
            m_valid_q    <= '0;
            m_data_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_pipe_q   <= cur_pipe_d;
            beat_cnt_q   <= beat_cnt_d;
            angle_cnt_q  <= angle_cnt_d;
            pipe_busy_q  <= pipe_busy_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign s_ready    = (state_q == StStream);
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign pipe_busy  = pipe_busy_q;
    assign cur_pipe   = cur_pipe_q;
    assign angle_idx  = angle_cnt_q;
    assign frame_done = frame_done_q;

`ifdef DISPATCH_STALL_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic        spurious_q, spurious_d;
    logic        frame_arm;

    assign frame_arm = (state_q == StIdle) && frame_start;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        spurious_d     = spurious_q;
        if (frame_arm) begin
            stall_cycles_d = '0;
            spurious_d     = 1'b0;
        end else if ((state_q == StSelect) && !pick_found && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (|(pipe_done & ~pipe_busy_q)) begin
            spurious_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            stall_cycles_q <= '0;
            spurious_q     <= 1'b0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            spurious_q     <= spurious_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign spurious_done = spurious_q;
`else
    // Stall statistics are not built; the scheduler behaves identically.
`endif

endmodule
